stopper_refill_ctrl: RTL
========================

// Module: stopper_refill_ctrl
// PURPOSE
//  Sequences stopper transfer from bulk stock into the capping-station dispenser.
//  Tracks the stock and dispenser levels and starts a batch refill when the dispenser drops to the low mark.
//  Also serves operator manual-add requests and consumes one stopper per completed seal.
//  Feeds the sealing FSM (stopper_avail) and the operator panel (alarms, levels).
// PARAMETERS
//  W        8   width of the stock and dispenser level counters
//  BATCH    15  maximum stoppers moved per refill
//  LOW_MARK 5   dispenser level at or below which an automatic refill is requested
//  CAP      20  dispenser capacity; must satisfy LOW_MARK < CAP < 2**W
// PORTS
//  clk           in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-low reset
//  stock_load    in   1  1-cycle pulse: stock_level <= stock_in
//  stock_in      in   W  new stock quantity
//  seal_done     in   1  1-cycle pulse from the sealing FSM: one stopper consumed
//  manual_add    in   1  1-cycle pulse: operator requests a refill
//  disp_level    out  W  stoppers currently in the dispenser
//  stock_level   out  W  stoppers currently in bulk stock
//  add_pulse     out  1  high for each cycle in which one stopper is transferred
//  refill_busy   out  1  high while state != IDLE
//  refill_done   out  1  1-cycle pulse at the end of each batch
//  stopper_avail out  1  disp_level != 0
//  low_alarm     out  1  disp_level <= LOW_MARK and stock_level == 0
//  stock_empty   out  1  stock_level == 0
//  err           out  1  1-cycle pulse on a rejected event
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state=IDLE; both levels = 0; all pulse outputs = 0.
//   - Hence stopper_avail=0, stock_empty=1, low_alarm=1.
//  FSM states: IDLE -> XFER -> DONE -> IDLE.
//  IDLE, start condition:
//   - Start when (disp_level <= LOW_MARK or manual_add) and stock_level != 0 and disp_level < CAP.
//   - On start, latch n = min(BATCH, stock_level, CAP - disp_level) into the batch counter, then go to XFER.
//   - The start is evaluated on the registered levels; the first transfer occurs in the cycle after the start.
//   - A start that fails its conditions is a no-op, with no err.
//  XFER, every cycle:
//   - add_pulse=1; stock_level-1; disp_level+1; batch counter-1.
//   - When the batch counter reaches 0, go to DONE. XFER lasts exactly n cycles.
//  DONE: refill_done=1 for one cycle, then return to IDLE.
//   - Re-evaluation starts in IDLE the next cycle, so a second batch can follow.
//  seal_done:
//   - Accepted in any state; disp_level decrements.
//   - If it coincides with a transfer in XFER, disp_level is net unchanged.
//   - With disp_level == 0 and no concurrent transfer, the level is held at 0 and err pulses.
//  stock_load:
//   - Accepted only in IDLE, and takes priority over a same-cycle start; the start is re-evaluated next cycle.
//   - In XFER or DONE it is ignored and err pulses.
//  manual_add: ignored outside IDLE (no err); ignored with stock_level == 0 or disp_level >= CAP.
//  Arithmetic:
//   - All counters are unsigned W bits and never wrap; batch sizing guarantees disp_level <= CAP.
//   - If stock_in > 2**W - 1, it is truncated by the port width.
//  Outputs:
//   - Levels and pulse outputs are registered.
//   - stopper_avail, low_alarm and stock_empty are combinational decodes of the registered levels.
// STRUCTURE
//  Package stopper_pkg:
//   - FSM state encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2).
//   - Default constants BATCH, LOW_MARK, CAP, W.
//  Sub-module sat_updown_counter (W-bit; inc, dec, load, data; saturates at 0 and at 2**W-1):
//   - Instantiated three times: stock, dispenser, batch.
//  Top level holds the FSM, the 3-way minimum for batch sizing, and the err logic.
// TESTING
//  1. Reset release with no load -> all levels 0, stock_empty=1, low_alarm=1, stopper_avail=0, no add_pulse.
//  2. stock_load 100 -> next cycle 15 add_pulses; disp=15, stock=85; refill_done 1 cycle.
//     Then refill_busy=0 and no further refill, since 15 > LOW_MARK.
//  3. From disp=15, stock=85: 10 seal_done -> disp=5 -> auto batch n=15 -> disp=20, stock=70.
//  4. stock=3, disp=0 -> batch n=3 -> disp=3, stock=0, stock_empty=1, low_alarm=1.
//     Then manual_add -> no transfer, no err.
//  5. seal_done on every XFER cycle of a batch -> disp_level constant; stock decrements by n.
//     stock_load mid-XFER -> err pulse and stock unchanged by the load.
//  6. Assert reset mid-XFER -> immediate IDLE, levels 0.
//     seal_done at disp=0 after release -> err pulse, disp stays 0.

Source files
------------

// File: rtl/stopper_pkg.sv
// Shared types and default sizing for the stopper refill controller.
package stopper_pkg;

  localparam int DEF_W        = 8;
  localparam int DEF_BATCH    = 15;
  localparam int DEF_LOW_MARK = 5;
  localparam int DEF_CAP      = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } refill_state_t;

endpackage

// File: rtl/sat_updown_counter.sv
// W-bit up/down counter with synchronous load that sticks at 0 and at all-ones.
module sat_updown_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  // Load wins; simultaneous inc and dec cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_data;
    end else if (i_inc && !i_dec) begin
      if (r_count != MAX) r_count <= r_count + ONE;
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/stopper_refill_ctrl.sv
// Moves stoppers from bulk stock into the capping dispenser in bounded batches
// and tracks both levels for the sealing FSM and the operator panel.
module stopper_refill_ctrl
  import stopper_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int BATCH    = DEF_BATCH,
  parameter int LOW_MARK = DEF_LOW_MARK,
  parameter int CAP      = DEF_CAP
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_stock_load,
  input  logic [W-1:0] i_stock_in,
  input  logic         i_seal_done,
  input  logic         i_manual_add,
  output logic [W-1:0] o_disp_level,
  output logic [W-1:0] o_stock_level,
  output logic         o_add_pulse,
  output logic         o_refill_busy,
  output logic         o_refill_done,
  output logic         o_stopper_avail,
  output logic         o_low_alarm,
  output logic         o_stock_empty,
  output logic         o_err
);

  localparam logic [W-1:0] BATCH_W = W'(BATCH);
  localparam logic [W-1:0] LOW_W   = W'(LOW_MARK);
  localparam logic [W-1:0] CAP_W   = W'(CAP);
  localparam logic [W-1:0] ONE_W   = W'(1);

  refill_state_t r_state;
  logic          r_add_pulse;
  logic          r_refill_done;
  logic          r_err;

  logic [W-1:0] w_disp;
  logic [W-1:0] w_stock;
  logic [W-1:0] w_batch;
  logic [W-1:0] w_room;
  logic [W-1:0] w_batch_n;
  logic         w_idle;
  logic         w_xfer;
  logic         w_stock_ld;
  logic         w_start;
  logic         w_rejected;

  assign w_idle     = (r_state == IDLE);
  assign w_xfer     = (r_state == XFER);
  assign w_stock_ld = i_stock_load && w_idle;
  assign w_room     = CAP_W - w_disp;

  // A stock load in the same cycle defers the start decision by one cycle.
  assign w_start = w_idle && !i_stock_load && (w_stock != '0) && (w_disp < CAP_W) &&
                   ((w_disp <= LOW_W) || i_manual_add);

  always_comb begin
    w_batch_n = BATCH_W;
    if (w_stock < w_batch_n) w_batch_n = w_stock;
    if (w_room < w_batch_n) w_batch_n = w_room;
  end

  assign w_rejected = (i_stock_load && !w_idle) ||
                      (i_seal_done && !w_xfer && (w_disp == '0));

  sat_updown_counter #(.W(W)) u_stock (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (1'b0),
    .i_dec   (w_xfer),
    .i_load  (w_stock_ld),
    .i_data  (i_stock_in),
    .o_count (w_stock)
  );

  sat_updown_counter #(.W(W)) u_disp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_xfer),
    .i_dec   (i_seal_done),
    .i_load  (1'b0),
    .i_data  ('0),
    .o_count (w_disp)
  );

  sat_updown_counter #(.W(W)) u_batch (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (1'b0),
    .i_dec   (w_xfer),
    .i_load  (w_start),
    .i_data  (w_batch_n),
    .o_count (w_batch)
  );

  // add_pulse is asserted for exactly the cycles spent in XFER.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_add_pulse   <= 1'b0;
      r_refill_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_rejected;
      case (r_state)
        IDLE: begin
          r_refill_done <= 1'b0;
          if (w_start) begin
            r_state     <= XFER;
            r_add_pulse <= 1'b1;
          end else begin
            r_add_pulse <= 1'b0;
          end
        end
        XFER: begin
          if (w_batch == ONE_W) begin
            r_state       <= DONE;
            r_add_pulse   <= 1'b0;
            r_refill_done <= 1'b1;
          end else begin
            r_add_pulse <= 1'b1;
          end
        end
        DONE: begin
          r_state       <= IDLE;
          r_add_pulse   <= 1'b0;
          r_refill_done <= 1'b0;
        end
        default: begin
          r_state       <= IDLE;
          r_add_pulse   <= 1'b0;
          r_refill_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_disp_level    = w_disp;
  assign o_stock_level   = w_stock;
  assign o_add_pulse     = r_add_pulse;
  assign o_refill_busy   = !w_idle;
  assign o_refill_done   = r_refill_done;
  assign o_err           = r_err;
  assign o_stopper_avail = (w_disp != '0);
  assign o_stock_empty   = (w_stock == '0);
  assign o_low_alarm     = (w_disp <= LOW_W) && (w_stock == '0);

endmodule
